cordic_sched: RTL
=================

# cordic_sched

Round-robin scheduler that shares one fully pipelined CORDIC sin/cos core among `NUM_REQ` requesters. It issues at most one angle per cycle into the core and tracks each in-flight operation with a tag pipeline matched to the core latency. It routes every returning sin/cos pair back to the requester that issued it. It sits between the angle-producing clients and the core, which has no valid or tag signals of its own.

## Interface
- `DATA_WIDTH`, 8: angle/sin/cos width, Q1.6 signed (1 sign, 1 integer, 6 fraction bits).
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CORE_LAT`, 12: core latency in cycles from angle presented to result valid.
- `MAX_OUT`, 4: maximum in-flight operations per requester, 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester angle valid.
- `req_angle`  in  NUM_REQ*DATA_WIDTH  packed angles; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant; a transfer occurs when valid & ready.
- `hold`  in  1  when high, no new grants; in-flight operations complete normally.
- `core_angle`  out  DATA_WIDTH  registered angle to the core.
- `core_cos`, `core_sin`  in  DATA_WIDTH  core results.
- `res_valid`  out  NUM_REQ  one-hot-or-zero, one-cycle result strobe.
- `res_cos`, `res_sin`  out  DATA_WIDTH  result shared by all requesters; qualified by `res_valid`.
- `busy`  out  1  high while any operation is in flight or any result is pending.

## Operation
- **Eligibility:** requester k is eligible when `req_valid[k]`, `outstanding[k] < MAX_OUT`, and `hold` is low.
- **Grant:** round-robin among eligible requesters, starting from pointer `rr_ptr`.
  - `req_ready` is combinational from eligibility and `rr_ptr`.
  - At most one grant per cycle.
  - On a grant to k, `rr_ptr` becomes (k+1) mod NUM_REQ.
  - With no grant, `rr_ptr` holds.
- **Issue:** on a grant, `core_angle` registers the granted angle. A tag {valid=1, id=k} enters a `CORE_LAT`-deep shift register.
  - With no grant, the tag entering the shift register is valid=0.
  - `core_angle` holds its last value.
- **Retire:** when a tag with valid=1 reaches the end of the shift register:
  - `core_cos` and `core_sin` are registered into `res_cos` and `res_sin`.
  - `res_valid[id]` pulses for one cycle.
  - Requesters must accept results unconditionally; there is no result backpressure.
- **Outstanding counters:** `outstanding[k]` increments on issue and decrements on retire. Issue and retire for the same k in the same cycle leave it unchanged. Counter width is $clog2(MAX_OUT+1).
- **Busy:** `busy` = any valid tag in the shift register OR any `res_valid` bit high.
- **Data:** angles and results pass through unmodified, with no arithmetic on data. Sign handling and scaling belong to the core.

## Timing
- **Issue latency:** a grant in cycle t puts the angle on `core_angle` in cycle t+1.
- **Result latency:** the result is sampled from the core in cycle t+1+CORE_LAT. `res_valid` and `res_*` appear in cycle t+2+CORE_LAT.
  - Total handshake-to-result latency is CORE_LAT+2 (14 at defaults).
- **Throughput:** one issue per cycle sustained. Results retire in issue order.
- **Reset values** (asynchronous, `rst` low):
  - `core_angle`=0, `res_cos`=0, `res_sin`=0, `res_valid`=0.
  - All tags invalid, all counters 0, `rr_ptr`=0.
  - `req_ready`=0 while in reset.
- **Reset mid-operation:** all in-flight operations are discarded. No `res_valid` is produced for them after release.
- **Hold:**
  - `hold` asserted in cycle t: `req_ready`=0 in cycle t.
  - Results already issued still retire on schedule.
- **Counter full:** a requester at `MAX_OUT` gets no grant. It becomes eligible in the same cycle its retire is registered, i.e. the cycle `res_valid` is high.
- **Single requester:** a lone active requester is granted every eligible cycle.
- **Wrap:** `rr_ptr` wraps from NUM_REQ-1 to 0.

## Structure
- **Shared package `cordic_pkg`:**
  - `CORE_LAT` default.
  - Q1.6 format constants.
  - Typedef `cordic_tag_t` {logic valid; logic [2:0] id}.
- **Sub-module `cordic_rr_arbiter`:**
  - Parameter `NUM_REQ`.
  - Inputs: eligible vector, `rr_ptr`.
  - Outputs: one-hot grant, grant index.
  - Purely combinational.
- The pointer register, tag shift register, counters and output registers live in `cordic_sched`.

## Test plan
- **Single request:** reset, then requester 0 presents 8'sh32 (0.78 rad) for one handshake at cycle 5 → `core_angle`=8'sh32 at cycle 6; model core returns cos=8'sh2D, sin=8'sh2D at cycle 18 → `res_valid`=4'b0001 with those values at cycle 19; `busy` low at cycle 20.
- **Round-robin fairness:** all four requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; results return in that order with matching ids.
- **Outstanding limit:** `MAX_OUT`=4, requester 2 alone valid continuously → exactly 4 grants, then `req_ready[2]`=0 until its first `res_valid` cycle, then one grant per retire.
- **Hold:** `hold` raised for 5 cycles while all requesters are valid → no grants during the hold, in-flight results still delivered, and granting resumes at the requester held in `rr_ptr`.
- **Reset mid-flight:** issue 3 operations, then assert `rst` low at issue+4 for 2 cycles → no `res_valid` ever appears, all outputs are 0, and counters are 0, so a new request completes normally with latency 14.
- **Same-cycle issue/retire:** requester 1 at `outstanding`=`MAX_OUT`-1, issuing in the same cycle a retire lands → counter unchanged, verified against a scoreboard.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC scheduler: Q1.6 data format, default core
// latency and the in-flight tag carried alongside each operation.
package cordic_pkg;

    localparam int CORE_LAT_DEF = 12;

    localparam int Q_WIDTH     = 8;
    localparam int Q_INT_BITS  = 1;
    localparam int Q_FRAC_BITS = 6;

    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } cordic_tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after rr_ptr.
module cordic_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx
);

    logic          found;
    logic [PW-1:0] idx;
    int            pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        pos       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = PW'(pos);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one pipelined CORDIC core among NUM_REQ requesters; a tag pipeline
// matched to the core latency routes each result back to its issuer.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = Q_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int CORE_LAT   = CORE_LAT_DEF,
    parameter int MAX_OUT    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          hold,
    output logic [DATA_WIDTH-1:0]         core_angle,
    input  logic [DATA_WIDTH-1:0]         core_cos,
    input  logic [DATA_WIDTH-1:0]         core_sin,
    output logic [NUM_REQ-1:0]            res_valid,
    output logic [DATA_WIDTH-1:0]         res_cos,
    output logic [DATA_WIDTH-1:0]         res_sin,
    output logic                          busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    retire_hit;
    logic [PW-1:0]         grant_idx;
    logic [PW-1:0]         rr_ptr;
    logic [DATA_WIDTH-1:0] grant_angle;
    logic                  issue;
    logic [CW-1:0]         outstanding [NUM_REQ];

    // Stage 0 is aligned with core_angle; stage CORE_LAT lines up with core results.
    cordic_tag_t tag_pipe [CORE_LAT+1];

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = rst && !hold && req_valid[k] && (outstanding[k] < CW'(MAX_OUT));
        end
    end

    cordic_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign issue     = |grant;

    always_comb begin
        grant_angle = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) grant_angle = req_angle[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        retire_hit = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            retire_hit[k] = tag_pipe[CORE_LAT].valid && (tag_pipe[CORE_LAT].id == TAG_ID_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            core_angle <= '0;
            res_valid  <= '0;
            res_cos    <= '0;
            res_sin    <= '0;
            for (int i = 0; i <= CORE_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            if (issue) begin
                rr_ptr     <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                core_angle <= grant_angle;
            end
            tag_pipe[0].valid <= issue;
            tag_pipe[0].id    <= TAG_ID_W'(grant_idx);
            for (int i = 1; i <= CORE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            res_valid <= retire_hit;
            if (tag_pipe[CORE_LAT].valid) begin
                res_cos <= core_cos;
                res_sin <= core_sin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) outstanding[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant[k] && !retire_hit[k])
                    outstanding[k] <= outstanding[k] + 1'b1;
                else if (!grant[k] && retire_hit[k])
                    outstanding[k] <= outstanding[k] - 1'b1;
            end
        end
    end

    always_comb begin
        busy = |res_valid;
        for (int i = 0; i <= CORE_LAT; i++) busy = busy | tag_pipe[i].valid;
    end

endmodule
